// File: rtl/registro_universal_if.sv
// Bus interface for registro_universal: control, data and status signals.
// The master drives control/data; the slave (the register) drives status.
interface registro_universal_if #(
  parameter int ANCHO = 16
);
  logic             Limpiar;
  logic             Habilitar;
  logic [2:0]       Modo;
  logic [ANCHO-1:0] Dato;
  logic             SerieIzq;
  logic             SerieDer;
  logic [ANCHO-1:0] Tupla;
  logic             Acarreo;
  logic             Cero;
  logic             Valido;

  modport master (
    output Limpiar, Habilitar, Modo, Dato, SerieIzq, SerieDer,
    input  Tupla, Acarreo, Cero, Valido
  );

  modport slave (
    input  Limpiar, Habilitar, Modo, Dato, SerieIzq, SerieDer,
    output Tupla, Acarreo, Cero, Valido
  );
endinterface

// File: rtl/registro_universal.sv
// Width-configurable universal register: load, shift, rotate, increment, decrement.
// Define REGISTRO_SATURACION_EN to saturate increment/decrement instead of wrapping.
module registro_universal #(
  parameter int               ANCHO       = 16,
  parameter logic [ANCHO-1:0] VALOR_RESET = '0
) (
  input logic                  Reloj,
  input logic                  Reiniciar,
  registro_universal_if.slave  bus
);

  localparam logic [2:0] M_MANTENER = 3'b000;
  localparam logic [2:0] M_CARGAR   = 3'b001;
  localparam logic [2:0] M_DESP_IZQ = 3'b010;
  localparam logic [2:0] M_DESP_DER = 3'b011;
  localparam logic [2:0] M_ROT_IZQ  = 3'b100;
  localparam logic [2:0] M_ROT_DER  = 3'b101;
  localparam logic [2:0] M_INC      = 3'b110;
  localparam logic [2:0] M_DEC      = 3'b111;

  logic [ANCHO-1:0] r_tupla;
  logic             r_acarreo;
  logic             r_valido;

  logic [ANCHO-1:0] w_tupla_sig;
  logic             w_acarreo_sig;
  logic             w_valido_sig;
  logic [ANCHO:0]   w_suma;
  logic [ANCHO:0]   w_resta;

  assign w_suma  = {1'b0, r_tupla} + {{ANCHO{1'b0}}, 1'b1};
  assign w_resta = {1'b0, r_tupla} - {{ANCHO{1'b0}}, 1'b1};

  always_comb begin
    w_tupla_sig   = r_tupla;
    w_acarreo_sig = r_acarreo;
    w_valido_sig  = 1'b0;
    if (bus.Limpiar) begin
      w_tupla_sig   = VALOR_RESET;
      w_acarreo_sig = 1'b0;
      w_valido_sig  = 1'b1;
    end else if (bus.Habilitar) begin
      w_valido_sig = 1'b1;
      case (bus.Modo)
        M_CARGAR: begin
          w_tupla_sig   = bus.Dato;
          w_acarreo_sig = 1'b0;
        end
        M_DESP_IZQ: begin
          w_tupla_sig   = {r_tupla[ANCHO-2:0], bus.SerieDer};
          w_acarreo_sig = r_tupla[ANCHO-1];
        end
        M_DESP_DER: begin
          w_tupla_sig   = {bus.SerieIzq, r_tupla[ANCHO-1:1]};
          w_acarreo_sig = r_tupla[0];
        end
        M_ROT_IZQ: begin
          w_tupla_sig   = {r_tupla[ANCHO-2:0], r_tupla[ANCHO-1]};
          w_acarreo_sig = r_tupla[ANCHO-1];
        end
        M_ROT_DER: begin
          w_tupla_sig   = {r_tupla[0], r_tupla[ANCHO-1:1]};
          w_acarreo_sig = r_tupla[0];
        end
        M_INC: begin
          w_acarreo_sig = w_suma[ANCHO];
`ifdef REGISTRO_SATURACION_EN
          w_tupla_sig   = w_suma[ANCHO] ? r_tupla : w_suma[ANCHO-1:0];
`else
          w_tupla_sig   = w_suma[ANCHO-1:0];
`endif
        end
        M_DEC: begin
          // Bit ANCHO of the extended difference is the borrow.
          w_acarreo_sig = w_resta[ANCHO];
`ifdef REGISTRO_SATURACION_EN
          w_tupla_sig   = w_resta[ANCHO] ? r_tupla : w_resta[ANCHO-1:0];
`else
          w_tupla_sig   = w_resta[ANCHO-1:0];
`endif
        end
        default: begin
          w_valido_sig = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge Reloj or negedge Reiniciar) begin
    if (!Reiniciar) begin
      r_tupla   <= VALOR_RESET;
      r_acarreo <= 1'b0;
      r_valido  <= 1'b0;
    end else begin
      r_tupla   <= w_tupla_sig;
      r_acarreo <= w_acarreo_sig;
      r_valido  <= w_valido_sig;
    end
  end

  assign bus.Tupla   = r_tupla;
  assign bus.Acarreo = r_acarreo;
  assign bus.Valido  = r_valido;
  assign bus.Cero    = (r_tupla == '0);

endmodule

// File: tb/tb_registro_universal.sv
// Bench for registro_universal: two instances (reset values 0 and A5A5) driven
// identically and compared against an arithmetic reference model.
module tb_registro_universal;

  localparam logic [15:0] RV0 = 16'h0000;
  localparam logic [15:0] RV1 = 16'hA5A5;

  logic Reloj;
  logic Reiniciar;

  registro_universal_if #(.ANCHO(16)) bus0 ();
  registro_universal_if #(.ANCHO(16)) bus1 ();

  registro_universal #(.ANCHO(16), .VALOR_RESET(RV0)) dut0 (
    .Reloj(Reloj), .Reiniciar(Reiniciar), .bus(bus0.slave));
  registro_universal #(.ANCHO(16), .VALOR_RESET(RV1)) dut1 (
    .Reloj(Reloj), .Reiniciar(Reiniciar), .bus(bus1.slave));

  int checks = 0;
  int errors = 0;

  logic [15:0] m_t [2];
  logic        m_c [2];
  logic        m_v [2];

  logic        lim, hab, si, sd;
  logic [2:0]  modo;
  logic [15:0] dato;

  initial begin
    Reloj = 1'b0;
    forever #5 Reloj = ~Reloj;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic drive(input logic l, input logic h, input logic [2:0] m,
                       input logic [15:0] d, input logic s_izq, input logic s_der);
    lim = l; hab = h; modo = m; dato = d; si = s_izq; sd = s_der;
    bus0.Limpiar = l; bus0.Habilitar = h; bus0.Modo = m; bus0.Dato = d;
    bus0.SerieIzq = s_izq; bus0.SerieDer = s_der;
    bus1.Limpiar = l; bus1.Habilitar = h; bus1.Modo = m; bus1.Dato = d;
    bus1.SerieIzq = s_izq; bus1.SerieDer = s_der;
  endtask

  task automatic modelo_reset();
    m_t[0] = RV0; m_c[0] = 1'b0; m_v[0] = 1'b0;
    m_t[1] = RV1; m_c[1] = 1'b0; m_v[1] = 1'b0;
  endtask

  // Next state from plain integer arithmetic on the register value.
  task automatic modelo_paso(input int k);
    int x, r;
    bit sat;
    sat = 1'b0;
`ifdef REGISTRO_SATURACION_EN
    sat = 1'b1;
`endif
    x = int'(m_t[k]);
    r = x;
    m_v[k] = 1'b0;
    if (lim) begin
      r = (k == 0) ? int'(RV0) : int'(RV1);
      m_c[k] = 1'b0; m_v[k] = 1'b1;
    end else if (hab) begin
      m_v[k] = (modo != 3'd0);
      case (modo)
        3'd1: begin r = int'(dato); m_c[k] = 1'b0; end
        3'd2: begin m_c[k] = (x >= 32768); r = (x * 2 + int'(sd)) % 65536; end
        3'd3: begin m_c[k] = (x % 2 == 1); r = x / 2 + int'(si) * 32768; end
        3'd4: begin m_c[k] = (x >= 32768); r = (x * 2 + x / 32768) % 65536; end
        3'd5: begin m_c[k] = (x % 2 == 1); r = x / 2 + (x % 2) * 32768; end
        3'd6: begin
          m_c[k] = (x == 65535);
          r = (x == 65535) ? (sat ? 65535 : 0) : x + 1;
        end
        3'd7: begin
          m_c[k] = (x == 0);
          r = (x == 0) ? (sat ? 0 : 65535) : x - 1;
        end
        default: r = x;
      endcase
    end
    m_t[k] = 16'(r);
  endtask

  task automatic comparar(input string tag);
    chk({tag, ".t0"}, bus0.Tupla, m_t[0]);
    chk({tag, ".c0"}, {15'd0, bus0.Acarreo}, {15'd0, m_c[0]});
    chk({tag, ".z0"}, {15'd0, bus0.Cero}, {15'd0, m_t[0] == 16'd0});
    chk({tag, ".v0"}, {15'd0, bus0.Valido}, {15'd0, m_v[0]});
    chk({tag, ".t1"}, bus1.Tupla, m_t[1]);
    chk({tag, ".c1"}, {15'd0, bus1.Acarreo}, {15'd0, m_c[1]});
    chk({tag, ".z1"}, {15'd0, bus1.Cero}, {15'd0, m_t[1] == 16'd0});
    chk({tag, ".v1"}, {15'd0, bus1.Valido}, {15'd0, m_v[1]});
  endtask

  task automatic paso(input string tag);
    @(posedge Reloj);
    if (Reiniciar) begin
      modelo_paso(0);
      modelo_paso(1);
    end
    #1;
    comparar(tag);
  endtask

  initial begin
    Reiniciar = 1'b0;
    drive(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);
    modelo_reset();
    repeat (2) @(posedge Reloj);
    @(negedge Reloj);
    Reiniciar = 1'b1;
    #1;
    comparar("reset");
    chk("reset_rv1", bus1.Tupla, 16'hA5A5);

    drive(1'b0, 1'b1, 3'd1, 16'h8001, 1'b0, 1'b0); paso("load8001");
    drive(1'b0, 1'b1, 3'd2, 16'h0000, 1'b0, 1'b1); paso("shl");
    chk("shl_const", bus0.Tupla, 16'h0003);
    drive(1'b0, 1'b1, 3'd3, 16'h0000, 1'b0, 1'b0); paso("shr");
    chk("shr_const", bus0.Tupla, 16'h0001);

    drive(1'b0, 1'b1, 3'd1, 16'h8001, 1'b0, 1'b0); paso("load8001b");
    drive(1'b0, 1'b1, 3'd5, 16'h0000, 1'b1, 1'b1); paso("rotr");
    chk("rotr_const", bus0.Tupla, 16'hC000);
    drive(1'b0, 1'b1, 3'd4, 16'h0000, 1'b0, 1'b0); paso("rotl");
    chk("rotl_const", bus0.Tupla, 16'h8001);

    drive(1'b0, 1'b1, 3'd1, 16'hFFFE, 1'b0, 1'b0); paso("loadFFFE");
    drive(1'b0, 1'b1, 3'd6, 16'h0000, 1'b0, 1'b0); paso("inc1");
    chk("inc1_const", bus0.Tupla, 16'hFFFF);
    paso("inc2");
`ifdef REGISTRO_SATURACION_EN
    chk("inc2_const", bus0.Tupla, 16'hFFFF);
`else
    chk("inc2_const", bus0.Tupla, 16'h0000);
`endif
    chk("inc2_carry", {15'd0, bus0.Acarreo}, 16'd1);
    drive(1'b0, 1'b1, 3'd1, 16'h0000, 1'b0, 1'b0); paso("load0");
    drive(1'b0, 1'b1, 3'd7, 16'h0000, 1'b0, 1'b0); paso("dec0");
`ifdef REGISTRO_SATURACION_EN
    chk("dec0_const", bus0.Tupla, 16'h0000);
`else
    chk("dec0_const", bus0.Tupla, 16'hFFFF);
`endif

    drive(1'b0, 1'b0, 3'd6, 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) paso("hold_dis");
    drive(1'b1, 1'b1, 3'd1, 16'h1234, 1'b0, 1'b0); paso("limpiar");
    chk("limpiar_rv1", bus1.Tupla, 16'hA5A5);

    drive(1'b0, 1'b1, 3'd1, 16'h0005, 1'b0, 1'b0); paso("load5");
    drive(1'b0, 1'b1, 3'd6, 16'h0000, 1'b0, 1'b0); paso("inc_a");
    paso("inc_b");
    #2;
    Reiniciar = 1'b0;
    modelo_reset();
    #1;
    comparar("async_rst");
    chk("async_rst_const", bus0.Tupla, 16'h0000);
    @(posedge Reloj); #1;
    comparar("rst_held");
    #3;
    Reiniciar = 1'b1;
    paso("resume");
    chk("resume_const", bus0.Tupla, 16'h0001);

    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(15) == 0), ($urandom_range(3) != 0),
            3'($urandom_range(7)), 16'($urandom), 1'($urandom), 1'($urandom));
      paso("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/registro_universal.md
Name: registro_universal

Overview:
- Parametrised successor to the fixed 16-bit enabled register.
- Width-configurable register with a synchronous mode select: hold, parallel load, logical shift left/right, rotate left/right, increment and decrement.
- Registered status outputs: carry/shift-out, zero flag and an update strobe.
- Used as the general-purpose datapath register (accumulator, counter, serial converter) in the ld2ud lab designs.

Parameters:
- ANCHO, 16, register width in bits (ANCHO >= 2).
- VALOR_RESET, 0, value loaded into Tupla on reset and on Limpiar (ANCHO bits).

Ports:
- Reloj  input  1  clock; all state changes on the rising edge.
- Reiniciar  input  1  asynchronous, active-low reset.
- Limpiar  input  1  synchronous clear to VALOR_RESET; has priority over Habilitar.
- Habilitar  input  1  operation enable; when 0, all state is held.
- Modo  input  3  operation select (encoding in Behaviour).
- Dato  input  ANCHO  parallel load value.
- SerieIzq  input  1  serial bit entering at the MSB on shift right.
- SerieDer  input  1  serial bit entering at the LSB on shift left.
- Tupla  output  ANCHO  register contents.
- Acarreo  output  1  carry, borrow or shifted-out bit of the last operation.
- Cero  output  1  1 when Tupla == 0.
- Valido  output  1  one-cycle strobe: Tupla was updated by an enabled operation.

Behaviour:
- Reset (Reiniciar = 0, asynchronous, at any time including mid-operation): Tupla = VALOR_RESET, Acarreo = 0, Valido = 0, Cero = (VALOR_RESET == 0). Takes effect immediately; no clock needed.
- Priority at a rising edge: Reiniciar, then Limpiar, then Habilitar.
- Limpiar = 1: Tupla = VALOR_RESET, Acarreo = 0, Valido = 1, whatever Habilitar and Modo are.
- Habilitar = 0 (and Limpiar = 0): Tupla and Acarreo hold; Valido = 0.
- Habilitar = 1: one-cycle latency; the result appears on Tupla after the edge. Modo encoding:
  - 000 hold: Tupla unchanged, Acarreo unchanged, Valido = 0.
  - 001 load: Tupla = Dato, Acarreo = 0.
  - 010 shift left: Tupla = {Tupla[ANCHO-2:0], SerieDer}, Acarreo = old Tupla[ANCHO-1].
  - 011 shift right: Tupla = {SerieIzq, Tupla[ANCHO-1:1]}, Acarreo = old Tupla[0].
  - 100 rotate left: Tupla = {Tupla[ANCHO-2:0], Tupla[ANCHO-1]}, Acarreo = old Tupla[ANCHO-1].
  - 101 rotate right: Tupla = {Tupla[0], Tupla[ANCHO-1:1]}, Acarreo = old Tupla[0].
  - 110 increment: ANCHO+1-bit sum; Tupla = low ANCHO bits, Acarreo = bit ANCHO. All-ones wraps to 0 with Acarreo = 1.
  - 111 decrement: Tupla = Tupla - 1 modulo 2^ANCHO; Acarreo = borrow. 0 wraps to all-ones with Acarreo = 1.
- Valido = 1 for exactly the cycle after any enabled operation other than hold, and after Limpiar.
- Cero is combinational from registered Tupla; no added latency.
- Serial inputs are sampled only in their shift mode and ignored otherwise.
- X on Modo while Habilitar = 1: treated as hold (default branch).

Optional Feature:
- Macro: REGISTRO_SATURACION_EN.
- Defined:
  - Increment at all-ones holds all-ones with Acarreo = 1.
  - Decrement at 0 holds 0 with Acarreo = 1.
  - Valido is still 1 in these cases.
  - All other modes are unchanged.
- Not defined: modular wrap as specified in Behaviour.

Test Plan (ANCHO = 16, VALOR_RESET = 16'h0000 unless stated):
- Hold Reiniciar = 0 for 2 cycles, then release -> Tupla = 0, Cero = 1, Valido = 0, Acarreo = 0. Repeat with VALOR_RESET = 16'hA5A5 -> Tupla = 16'hA5A5, Cero = 0.
- Load 16'h8001, then shift left with SerieDer = 1 -> Tupla = 16'h0003, Acarreo = 1. Then shift right with SerieIzq = 0 -> Tupla = 16'h0001, Acarreo = 1.
- Load 16'h8001, rotate right -> Tupla = 16'hC000, Acarreo = 1. Rotate left -> Tupla = 16'h8001, Acarreo = 1.
- Load 16'hFFFE, increment twice -> 16'hFFFF with Acarreo = 0, then 16'h0000 with Acarreo = 1 and Cero = 1. With REGISTRO_SATURACION_EN -> second step stays 16'hFFFF, Acarreo = 1. Decrement from 0 -> 16'hFFFF, Acarreo = 1 (saturated build: 0).
- Habilitar = 0 with Modo = 110 for 4 cycles -> Tupla unchanged, Valido = 0. Limpiar = 1 with Habilitar = 1, Modo = 001, Dato = 16'h1234 -> Tupla = VALOR_RESET, Valido = 1.
- Assert Reiniciar low between edges during an increment sequence starting from 16'h0005 -> Tupla = 0 immediately, before the next edge. Counting resumes from 0 after release: first enabled increment gives 16'h0001.
